// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Fetch stage that sits directly in front of program_memory. It owns the
// program counter, drives the memory's combinational read address, and
// captures each returned word with its address into a 2-entry prefetch FIFO.
// The decoder pulls entries from the FIFO head over a valid/ready handshake.
// A redirect request flushes the FIFO and restarts fetch at a new address.
// start/done sequence whole program runs.
//
// Optional build macro:
//   FETCH_NOP_SKIP_EN - when defined, fetched words whose opcode (bits [3:0])
//                       is 4'b1111 are dropped instead of being buffered.
//
// Ports:
//   clk                 rising-edge clock
//   rst                 asynchronous active-high reset
//   start               pulse, begins a run from address 0 (IDLE/DONE only)
//   instruction_address read address to program_memory (equals the PC)
//   instruction         word returned by program_memory in the same cycle
//   instr_out           FIFO head instruction
//   instr_pc            address of instr_out
//   instr_valid         FIFO head holds a valid entry
//   instr_ready         decoder accepts the head when instr_valid is high
//   redirect_valid      flush and restart fetch at redirect_address
//   redirect_address    new PC for a redirect
//   done                high once the program has been fully delivered
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter int BITS_FOR_INSTRUCTIONS  = 5,
  parameter int INSTRUCTION_WIDTH      = 16,
  parameter int NUMBER_OF_INSTRUCTIONS = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  output logic [BITS_FOR_INSTRUCTIONS-1:0] instruction_address,
  input  logic [INSTRUCTION_WIDTH-1:0]     instruction,
  output logic [INSTRUCTION_WIDTH-1:0]     instr_out,
  output logic [BITS_FOR_INSTRUCTIONS-1:0] instr_pc,
  output logic                             instr_valid,
  input  logic                             instr_ready,
  input  logic                             redirect_valid,
  input  logic [BITS_FOR_INSTRUCTIONS-1:0] redirect_address,
  output logic                             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [BITS_FOR_INSTRUCTIONS-1:0] LAST_PC =
    BITS_FOR_INSTRUCTIONS'(NUMBER_OF_INSTRUCTIONS - 1);

  state_t                           state;
  state_t                           state_next;
  logic [BITS_FOR_INSTRUCTIONS-1:0] pc;
  logic [BITS_FOR_INSTRUCTIONS-1:0] pc_next;
  logic [1:0]                       count;
  logic [1:0]                       count_next;

  // Two FIFO slots: the head feeds the decoder, the tail holds the second entry.
  logic [INSTRUCTION_WIDTH-1:0]     head_instr;
  logic [BITS_FOR_INSTRUCTIONS-1:0] head_pc;
  logic [INSTRUCTION_WIDTH-1:0]     tail_instr;
  logic [BITS_FOR_INSTRUCTIONS-1:0] tail_pc;

  logic redirect_take;
  logic pop;
  logic is_nop;
  logic fetch;
  logic push;

  assign instruction_address = pc;
  assign instr_out           = head_instr;
  assign instr_pc            = head_pc;
  assign instr_valid         = (count != 2'd0);
  assign done                = (state == S_DONE);

  // Handshake qualifiers. A fetch is allowed when the FIFO has room, or will
  // have room because the head leaves this cycle; a skipped NOP never needs
  // room. A redirect discards any push in the same cycle.
  always_comb begin
    redirect_take = redirect_valid && (state != S_IDLE);
    pop           = instr_valid && instr_ready;
`ifdef FETCH_NOP_SKIP_EN
    is_nop        = (instruction[3:0] == 4'b1111);
`else
    is_nop        = 1'b0;
`endif
    fetch         = (state == S_RUN) && ((count != 2'd2) || pop || is_nop);
    push          = fetch && !is_nop && !redirect_take;
  end

  // Occupancy after this edge; a redirect empties the FIFO regardless of any
  // handshake (the handshake itself still counts as completed).
  always_comb begin
    count_next = count;
    if (redirect_take) begin
      count_next = 2'd0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count + 2'd1;
        2'b01:   count_next = count - 2'd1;
        default: count_next = count;
      endcase
    end
  end

  // Sequencing and PC update. Redirect outranks start, fetch and the
  // DRAIN->DONE transition. Fetching the last address parks the PC there.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    if (redirect_take) begin
      state_next = S_RUN;
      pc_next    = redirect_address;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state_next = S_RUN;
            pc_next    = '0;
          end
        end
        S_RUN: begin
          if (fetch) begin
            if (pc == LAST_PC) begin
              state_next = S_DRAIN;
            end else begin
              pc_next = pc + BITS_FOR_INSTRUCTIONS'(1);
            end
          end
        end
        S_DRAIN: begin
          if (count_next == 2'd0) begin
            state_next = S_DONE;
          end
        end
        S_DONE: begin
          if (start) begin
            state_next = S_RUN;
            pc_next    = '0;
          end
        end
        default: begin
          state_next = S_IDLE;
          pc_next    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      pc    <= '0;
      count <= 2'd0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      count <= count_next;
    end
  end

  // FIFO storage. On a pop the tail shifts into the head; a simultaneous push
  // lands in whichever slot becomes the new tail so order is preserved.
  // Slot contents are left untouched on a redirect since count is cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_instr <= '0;
      head_pc    <= '0;
      tail_instr <= '0;
      tail_pc    <= '0;
    end else if (!redirect_take) begin
      if (pop) begin
        if (push && (count == 2'd1)) begin
          head_instr <= instruction;
          head_pc    <= pc;
        end else begin
          head_instr <= tail_instr;
          head_pc    <= tail_pc;
        end
        if (push && (count == 2'd2)) begin
          tail_instr <= instruction;
          tail_pc    <= pc;
        end
      end else if (push) begin
        if (count == 2'd0) begin
          head_instr <= instruction;
          head_pc    <= pc;
        end else begin
          tail_instr <= instruction;
          tail_pc    <= pc;
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Directed testbench for instruction_fetch_unit. The bench models
// program_memory as a fixed combinational table (prog_word) and checks the
// fetch unit's outputs against hand-derived expectations on each falling edge.
// Inputs are changed on falling edges as well. Honours FETCH_NOP_SKIP_EN:
// address 0 holds a NOP, so the first delivered pc depends on the macro.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  localparam int BITS = 5;
  localparam int IW   = 16;
  localparam int NUM  = 32;

`ifdef FETCH_NOP_SKIP_EN
  localparam int FIRST_PC = 1;
`else
  localparam int FIRST_PC = 0;
`endif

  logic            clk;
  logic            rst;
  logic            start;
  logic [BITS-1:0] instruction_address;
  logic [IW-1:0]   instruction;
  logic [IW-1:0]   instr_out;
  logic [BITS-1:0] instr_pc;
  logic            instr_valid;
  logic            instr_ready;
  logic            redirect_valid;
  logic [BITS-1:0] redirect_address;
  logic            done;

  int vectors;
  int miscompares;

  instruction_fetch_unit #(
    .BITS_FOR_INSTRUCTIONS (BITS),
    .INSTRUCTION_WIDTH     (IW),
    .NUMBER_OF_INSTRUCTIONS(NUM)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .instruction_address(instruction_address),
    .instruction        (instruction),
    .instr_out          (instr_out),
    .instr_pc           (instr_pc),
    .instr_valid        (instr_valid),
    .instr_ready        (instr_ready),
    .redirect_valid     (redirect_valid),
    .redirect_address   (redirect_address),
    .done               (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program image: address 0 is a NOP, even addresses 10..16 carry opcode 6,
  // address 17 is a STORE with reg field 01, everything else is unique filler.
  function automatic logic [IW-1:0] prog_word(input logic [BITS-1:0] a);
    case (a)
      5'd0:                    prog_word = 16'h000F;
      5'd10, 5'd12, 5'd14, 5'd16: prog_word = {2'b00, 5'b00000, a, 4'h6};
      5'd17:                   prog_word = 16'h4007;
      default:                 prog_word = {2'b10, 5'b00000, a, 4'h2};
    endcase
  endfunction

  assign instruction = prog_word(instruction_address);

  // Sequencing helpers (no checking inside).
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_program();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_redirect(input logic [BITS-1:0] a);
    redirect_valid   = 1'b1;
    redirect_address = a;
    @(negedge clk);
    redirect_valid   = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    instr_ready = 1'b0;
    start_program();
    repeat (3) @(negedge clk);
    vectors++;
    if (instr_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_prefill_valid: got %b expected 1", instr_valid);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (instr_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_async_valid: got %b expected 0", instr_valid);
    end
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_async_done: got %b expected 0", done);
    end
    vectors++;
    if (instruction_address !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_async_addr: got %0d expected 0", instruction_address);
    end
    vectors++;
    if ({instr_out, instr_pc} !== 21'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_async_head: got %h/%0d expected 0/0", instr_out, instr_pc);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if ({instr_valid, done, instruction_address} !== 7'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_stays_idle: got valid=%b done=%b addr=%0d expected 0/0/0",
               instr_valid, done, instruction_address);
    end
  endtask

  task automatic test_straight_run();
    do_reset();
    instr_ready = 1'b1;
    start_program();
    vectors++;
    if ({instr_valid, instruction_address} !== 6'd0) begin
      miscompares++;
      $display("[TB] FAIL run_after_start: got valid=%b addr=%0d expected 0/0",
               instr_valid, instruction_address);
    end
    repeat (1 + FIRST_PC) @(negedge clk);
    for (int p = FIRST_PC; p < NUM; p++) begin
      vectors++;
      if ({instr_valid, instr_pc} !== {1'b1, 5'(p)}) begin
        miscompares++;
        $display("[TB] FAIL run_pc: got valid=%b pc=%0d expected 1/%0d", instr_valid, instr_pc, p);
      end
      vectors++;
      if (instr_out !== prog_word(5'(p))) begin
        miscompares++;
        $display("[TB] FAIL run_word: got %h expected %h at pc %0d", instr_out, prog_word(5'(p)), p);
      end
      if (p == 10 || p == 12 || p == 14 || p == 16) begin
        vectors++;
        if (instr_out[3:0] !== 4'b0110) begin
          miscompares++;
          $display("[TB] FAIL run_opcode6: got %h expected 6 at pc %0d", instr_out[3:0], p);
        end
      end
      vectors++;
      if (done !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL run_done_early: got %b expected 0 at pc %0d", done, p);
      end
      @(negedge clk);
    end
    vectors++;
    if ({done, instr_valid} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL run_done: got done=%b valid=%b expected 1/0", done, instr_valid);
    end
  endtask

  task automatic test_nop();
    do_reset();
    instr_ready = 1'b0;
    start_program();
    repeat (1 + FIRST_PC) @(negedge clk);
`ifdef FETCH_NOP_SKIP_EN
    vectors++;
    if ({instr_valid, instr_pc, instr_out[3:0]} !== {1'b1, 5'd1, 4'h2}) begin
      miscompares++;
      $display("[TB] FAIL nop_skipped: got valid=%b pc=%0d op=%h expected 1/1/2",
               instr_valid, instr_pc, instr_out[3:0]);
    end
`else
    vectors++;
    if ({instr_valid, instr_pc, instr_out[3:0]} !== {1'b1, 5'd0, 4'hF}) begin
      miscompares++;
      $display("[TB] FAIL nop_delivered: got valid=%b pc=%0d op=%h expected 1/0/f",
               instr_valid, instr_pc, instr_out[3:0]);
    end
`endif
  endtask

  task automatic test_backpressure();
    do_reset();
    instr_ready = 1'b0;
    start_program();
    repeat (3) @(negedge clk);
    vectors++;
    if ({instr_valid, instr_pc, instruction_address} !== {1'b1, 5'(FIRST_PC), 5'(FIRST_PC + 2)}) begin
      miscompares++;
      $display("[TB] FAIL bp_full: got valid=%b pc=%0d addr=%0d expected 1/%0d/%0d",
               instr_valid, instr_pc, instruction_address, FIRST_PC, FIRST_PC + 2);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({instr_pc, instruction_address} !== {5'(FIRST_PC), 5'(FIRST_PC + 2)}) begin
      miscompares++;
      $display("[TB] FAIL bp_hold: got pc=%0d addr=%0d expected %0d/%0d",
               instr_pc, instruction_address, FIRST_PC, FIRST_PC + 2);
    end
    instr_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      vectors++;
      if ({instr_valid, instr_pc} !== {1'b1, 5'(FIRST_PC + k)}) begin
        miscompares++;
        $display("[TB] FAIL bp_release: got valid=%b pc=%0d expected 1/%0d",
                 instr_valid, instr_pc, FIRST_PC + k);
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    instr_ready = 1'b0;
    start_program();
    repeat (3) @(negedge clk);
    do_redirect(5'd17);
    vectors++;
    if ({instr_valid, instruction_address} !== {1'b0, 5'd17}) begin
      miscompares++;
      $display("[TB] FAIL redir_flush: got valid=%b addr=%0d expected 0/17",
               instr_valid, instruction_address);
    end
    @(negedge clk);
    vectors++;
    if ({instr_valid, instr_pc, instr_out} !== {1'b1, 5'd17, 16'h4007}) begin
      miscompares++;
      $display("[TB] FAIL redir_head: got valid=%b pc=%0d word=%h expected 1/17/4007",
               instr_valid, instr_pc, instr_out);
    end
    instr_ready = 1'b1;
    for (int k = 18; k <= 19; k++) begin
      @(negedge clk);
      vectors++;
      if ({instr_valid, instr_pc} !== {1'b1, 5'(k)}) begin
        miscompares++;
        $display("[TB] FAIL redir_follow: got valid=%b pc=%0d expected 1/%0d", instr_valid, instr_pc, k);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    instr_ready = 1'b1;
    start_program();
    repeat (1 + FIRST_PC) @(negedge clk);
    // Head is valid and ready, a push is due: redirect in the same cycle.
    do_redirect(5'd5);
    vectors++;
    if ({instr_valid, instruction_address} !== {1'b0, 5'd5}) begin
      miscompares++;
      $display("[TB] FAIL simul_flush: got valid=%b addr=%0d expected 0/5",
               instr_valid, instruction_address);
    end
    for (int k = 5; k <= 6; k++) begin
      @(negedge clk);
      vectors++;
      if ({instr_valid, instr_pc, instr_out} !== {1'b1, 5'(k), prog_word(5'(k))}) begin
        miscompares++;
        $display("[TB] FAIL simul_next: got valid=%b pc=%0d word=%h expected 1/%0d/%h",
                 instr_valid, instr_pc, instr_out, k, prog_word(5'(k)));
      end
    end
    // Short run to the end, then redirect out of DONE.
    do_redirect(5'd29);
    for (int k = 29; k <= 31; k++) begin
      @(negedge clk);
      vectors++;
      if ({instr_valid, instr_pc} !== {1'b1, 5'(k)}) begin
        miscompares++;
        $display("[TB] FAIL tail_pc: got valid=%b pc=%0d expected 1/%0d", instr_valid, instr_pc, k);
      end
    end
    @(negedge clk);
    vectors++;
    if ({done, instr_valid, instruction_address} !== {2'b10, 5'd31}) begin
      miscompares++;
      $display("[TB] FAIL tail_done: got done=%b valid=%b addr=%0d expected 1/0/31",
               done, instr_valid, instruction_address);
    end
    do_redirect(5'd3);
    vectors++;
    if ({done, instr_valid, instruction_address} !== {2'b00, 5'd3}) begin
      miscompares++;
      $display("[TB] FAIL done_redirect: got done=%b valid=%b addr=%0d expected 0/0/3",
               done, instr_valid, instruction_address);
    end
    @(negedge clk);
    vectors++;
    if ({instr_valid, instr_pc} !== {1'b1, 5'd3}) begin
      miscompares++;
      $display("[TB] FAIL done_redirect_pc: got valid=%b pc=%0d expected 1/3", instr_valid, instr_pc);
    end
    // Back to DONE once more and restart with start.
    do_redirect(5'd31);
    repeat (2) @(negedge clk);
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL done_again: got %b expected 1", done);
    end
    start_program();
    vectors++;
    if ({done, instruction_address} !== 6'd0) begin
      miscompares++;
      $display("[TB] FAIL done_start: got done=%b addr=%0d expected 0/0", done, instruction_address);
    end
    repeat (1 + FIRST_PC) @(negedge clk);
    vectors++;
    if ({instr_valid, instr_pc} !== {1'b1, 5'(FIRST_PC)}) begin
      miscompares++;
      $display("[TB] FAIL done_start_pc: got valid=%b pc=%0d expected 1/%0d",
               instr_valid, instr_pc, FIRST_PC);
    end
  endtask

  initial begin
    vectors          = 0;
    miscompares      = 0;
    rst              = 1'b1;
    start            = 1'b0;
    instr_ready      = 1'b0;
    redirect_valid   = 1'b0;
    redirect_address = '0;
    @(negedge clk);
    test_reset();
    test_straight_run();
    test_nop();
    test_backpressure();
    test_redirect();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage directly upstream of program_memory. Owns the program counter and drives the memory's combinational read address. Captures each returned instruction, with its address, into a 2-entry prefetch buffer. Presents buffered instructions to the decoder over a valid/ready handshake, and supports a redirect (jump/flush) request and start/done sequencing.

Parameters:
BITS_FOR_INSTRUCTIONS, 5, width of PC and instruction_address
INSTRUCTION_WIDTH, 16, instruction word width ({2b reg field, 10b operand, 4b opcode})
NUMBER_OF_INSTRUCTIONS, 32, program length; last fetched address = NUMBER_OF_INSTRUCTIONS-1

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  pulse; begins fetch from address 0 (IDLE/DONE only)
instruction_address  output  BITS_FOR_INSTRUCTIONS  to program_memory; equals PC combinationally
instruction  input  INSTRUCTION_WIDTH  from program_memory, valid same cycle as address
instr_out  output  INSTRUCTION_WIDTH  buffer head instruction
instr_pc  output  BITS_FOR_INSTRUCTIONS  address of instr_out
instr_valid  output  1  buffer head valid
instr_ready  input  1  decoder accepts head when instr_valid&instr_ready
redirect_valid  input  1  flush buffer, restart fetch at redirect_address
redirect_address  input  BITS_FOR_INSTRUCTIONS  new PC
done  output  1  high in DONE state

Behaviour:
- Reset (async, any time incl. mid-run): state IDLE; PC=0; buffer count=0; instr_valid=0; instr_out=0; instr_pc=0; done=0. Buffer contents are discarded.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: no fetch. start=1 at an edge -> RUN with PC=0.
- RUN: fetch happens at an edge when count<2, or count==2 with a pop in the same cycle. Fetch pushes {PC, instruction} at the tail and increments PC. If the fetched PC == NUMBER_OF_INSTRUCTIONS-1: PC holds, state -> DRAIN. With no fetch, PC holds, so instruction_address is stable under backpressure.
- DRAIN: no fetch. When count reaches 0 (after the final pop) -> DONE.
- DONE: done=1, instr_valid=0. start -> RUN, PC=0, done=0 next cycle.
- start is ignored in RUN/DRAIN.
- Buffer: 2-entry FIFO. Head drives instr_out/instr_pc (registered). instr_valid = (count!=0). Push and pop may occur in the same cycle; count is unchanged and order is preserved. No push occurs when full without a pop. No pop occurs when empty.
- Latency: start sampled at edge N -> PC 0 fetched at edge N+1 -> instr_valid=1 with pc 0 after edge N+1. With instr_ready held high, throughput is 1 instruction/cycle.
- redirect_valid (RUN/DRAIN/DONE; ignored in IDLE) at an edge:
  - A head handshake in that cycle counts as completed.
  - The buffer is then flushed (count=0, instr_valid=0 next cycle).
  - Any same-cycle push is discarded.
  - PC=redirect_address; state -> RUN; done=0.
- Redirect has priority over start, push and the DRAIN->DONE transition.
- PC arithmetic is unsigned, width BITS_FOR_INSTRUCTIONS. PC never wraps; end of program is detected by the DRAIN transition.

Optional Feature:
FETCH_NOP_SKIP_EN
- Defined: a fetched word with opcode[3:0]==4'b1111 (NOP) is not pushed. PC still increments and the end-of-program check still applies. A fetch that is skipped is allowed regardless of count.
- Undefined: NOPs are delivered like any other instruction.

Test Plan:
- Reset: assert rst mid-RUN with 2 entries buffered -> immediately instr_valid=0, done=0, instruction_address=0. After release, state stays IDLE (no fetch without start).
- Straight run: start, instr_ready=1 -> 32 handshakes with instr_pc 0..31 in consecutive cycles. instr_out[3:0] at pc 10/12/14/16 = 4'b0110. done=1 one cycle after the last pop.
- Backpressure: start, instr_ready=0 -> count=2, instruction_address holds 2, instr_pc holds 0. Raising ready -> pcs 0,1,2,... with no loss or duplication.
- Redirect: during RUN, redirect_valid with redirect_address=17 -> next instr_valid head has instr_pc=17, instr_out=16'h4007 (reg field 2'b01, STORE). Earlier buffered entries are never presented.
- Simultaneous: redirect in the same cycle as a head handshake and a push -> head counted as consumed, pushed entry dropped, next delivered pc = redirect_address. Redirect in DONE restarts RUN.
- FETCH_NOP_SKIP_EN defined: start -> first delivered instr_pc=1 (address 0 NOP skipped). Undefined: first delivered instr_pc=0, opcode 4'b1111.
